// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared read-state enum, frame defaults and pixel type for the OV7670 FIFO read path
package ov7670_pkg;

   localparam int DEF_H_ACTIVE = 320;
   localparam int DEF_V_ACTIVE = 240;

   typedef enum logic [1:0] {
      IDLE,
      RRST,
      READ,
      DONE
   } rd_state_t;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

endpackage

// File: rtl/ov7670_rclk_gen.sv
// rtl/ov7670_rclk_gen.sv - FIFO_RCLK generator with phase divider, stall hold and enable
module ov7670_rclk_gen #(
   parameter int RCLK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic hold,
   output logic rclk,
   output logic rise,
   output logic fall
);

   localparam int CW = (RCLK_DIV > 1) ? $clog2(RCLK_DIV) : 1;
   localparam logic [CW-1:0] PHASE_LAST = CW'(RCLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          phase_end;

   assign phase_end = (cnt == PHASE_LAST);

   // Strobes flag the coming edge; hold only ever stretches the high phase.
   assign rise = en && !rclk && phase_end;
   assign fall = en && rclk && phase_end && !hold;

   // Phase counter: toggle rclk every RCLK_DIV cycles, park low when disabled.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         rclk <= 1'b0;
         cnt  <= '0;
      end else if (rise || fall) begin
         rclk <= !rclk;
         cnt  <= '0;
      end else if (!phase_end) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ov7670_fifo_read.sv
// rtl/ov7670_fifo_read.sv - AL422B read controller packing bytes into RGB565; OV7670_RD_BYTE_SWAP_EN puts the even byte low
module ov7670_fifo_read
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int RCLK_DIV    = 1,
   parameter int RRST_CYCLES = 4
) (
   input  logic        SYS_CLK,
   input  logic        RST,
   input  logic        WR_FRAME,
   input  logic [7:0]  FIFO_DO,
   output logic        FIFO_RCLK,
   output logic        FIFO_RRST,
   output logic        FIFO_OE,
   output logic [15:0] PIX_DATA,
   output logic        PIX_VALID,
   input  logic        PIX_READY,
   output logic        PIX_SOF,
   output logic        PIX_EOL,
   output logic        PIX_EOF,
   output logic        R_IDLE
);

   localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int NW = $clog2(RRST_CYCLES + 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(H_ACTIVE - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(V_ACTIVE - 1);
   localparam logic [NW-1:0] RRST_LAST = NW'(RRST_CYCLES);

   rd_state_t     state, state_nxt;
   logic          wr_frame_d;
   logic          start, accept, load, line_end;
   logic          rclk_en, rclk_hold, rclk_rise, rclk_fall;
   logic [NW-1:0] rrst_cnt;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          odd, frame_done;
   logic [7:0]    first_byte;
   rgb565_t       pix_q, pix_next;

   assign start     = (state == IDLE) && WR_FRAME && !wr_frame_d;
   assign accept    = PIX_VALID && PIX_READY;
   assign load      = (state == READ) && rclk_fall && odd;
   assign line_end  = (col == COL_LAST);
   assign rclk_en   = (state == RRST) || ((state == READ) && !frame_done);
   assign rclk_hold = odd && PIX_VALID && !PIX_READY;
   assign PIX_DATA  = pix_q;

`ifdef OV7670_RD_BYTE_SWAP_EN
   assign pix_next = {FIFO_DO, first_byte};
`else
   assign pix_next = {first_byte, FIFO_DO};
`endif

   ov7670_rclk_gen #(
      .RCLK_DIV (RCLK_DIV)
   ) u_rclk_gen (
      .clk  (SYS_CLK),
      .rst  (RST),
      .en   (rclk_en),
      .hold (rclk_hold),
      .rclk (FIFO_RCLK),
      .rise (rclk_rise),
      .fall (rclk_fall)
   );

   // State register.
   always_ff @(posedge SYS_CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: reset pointer for RRST_CYCLES clocks, read until EOF is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RRST;
         RRST: if (rclk_fall && (rrst_cnt == RRST_LAST)) state_nxt = READ;
         READ: if (frame_done && accept) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FIFO control pins and idle flag decoded from state.
   always_comb begin
      FIFO_RRST = 1'b1;
      FIFO_OE   = 1'b1;
      R_IDLE    = 1'b0;
      case (state)
         IDLE:    R_IDLE    = 1'b1;
         RRST:    FIFO_RRST = 1'b0;
         READ:    FIFO_OE   = 1'b0;
         default: ;
      endcase
   end

   // Edge detect, reset-cycle count, byte parity and raster position.
   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         wr_frame_d <= 1'b0;
         rrst_cnt   <= '0;
         odd        <= 1'b0;
         frame_done <= 1'b0;
         first_byte <= '0;
         col        <= '0;
         row        <= '0;
      end else begin
         wr_frame_d <= WR_FRAME;
         if (start) begin
            rrst_cnt   <= '0;
            odd        <= 1'b0;
            frame_done <= 1'b0;
            col        <= '0;
            row        <= '0;
         end
         if ((state == RRST) && rclk_rise) rrst_cnt <= rrst_cnt + 1'b1;
         if ((state == READ) && rclk_fall) begin
            odd <= !odd;
            if (!odd) first_byte <= FIFO_DO;
         end
         if (load) begin
            if (line_end) begin
               col <= '0;
               if (row == ROW_LAST) begin
                  row        <= '0;
                  frame_done <= 1'b1;
               end else begin
                  row <= row + 1'b1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Output register: load a pixel on the odd-byte capture, drop valid on accept.
   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         pix_q     <= '0;
         PIX_VALID <= 1'b0;
         PIX_SOF   <= 1'b0;
         PIX_EOL   <= 1'b0;
         PIX_EOF   <= 1'b0;
      end else if (load) begin
         pix_q     <= pix_next;
         PIX_VALID <= 1'b1;
         PIX_SOF   <= (row == '0) && (col == '0);
         PIX_EOL   <= line_end;
         PIX_EOF   <= line_end && (row == ROW_LAST);
      end else if (PIX_READY) begin
         PIX_VALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ov7670_fifo_read.sv
// tb/tb_ov7670_fifo_read.sv - scoreboard bench for ov7670_fifo_read with AL422B read model
module tb_ov7670_fifo_read;

   typedef struct packed {
      logic [15:0] data;
      logic        sof;
      logic        eol;
      logic        eof;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_frame, wr_frame_b;
   logic [7:0]  fifo_do, fifo_do_b;
   logic        fifo_rclk, fifo_rrst, fifo_oe;
   logic        fifo_rclk_b, fifo_rrst_b, fifo_oe_b;
   logic [15:0] pix_data, pix_data_b;
   logic        pix_valid, pix_ready, pix_sof, pix_eol, pix_eof, r_idle;
   logic        pix_valid_b, pix_ready_b, pix_sof_b, pix_eol_b, pix_eof_b, r_idle_b;

   logic [7:0]  mem [0:15];
   logic [3:0]  rd_ptr, rd_ptr_b;
   exp_t        sb [$];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   ov7670_fifo_read #(.H_ACTIVE(4), .V_ACTIVE(2), .RCLK_DIV(1), .RRST_CYCLES(4)) dut (
      .SYS_CLK(clk), .RST(rst), .WR_FRAME(wr_frame), .FIFO_DO(fifo_do),
      .FIFO_RCLK(fifo_rclk), .FIFO_RRST(fifo_rrst), .FIFO_OE(fifo_oe),
      .PIX_DATA(pix_data), .PIX_VALID(pix_valid), .PIX_READY(pix_ready),
      .PIX_SOF(pix_sof), .PIX_EOL(pix_eol), .PIX_EOF(pix_eof), .R_IDLE(r_idle)
   );

   ov7670_fifo_read #(.H_ACTIVE(4), .V_ACTIVE(2), .RCLK_DIV(3), .RRST_CYCLES(4)) dut_b (
      .SYS_CLK(clk), .RST(rst), .WR_FRAME(wr_frame_b), .FIFO_DO(fifo_do_b),
      .FIFO_RCLK(fifo_rclk_b), .FIFO_RRST(fifo_rrst_b), .FIFO_OE(fifo_oe_b),
      .PIX_DATA(pix_data_b), .PIX_VALID(pix_valid_b), .PIX_READY(pix_ready_b),
      .PIX_SOF(pix_sof_b), .PIX_EOL(pix_eol_b), .PIX_EOF(pix_eof_b), .R_IDLE(r_idle_b)
   );

   // AL422B read port: pointer cleared while RRST is low, data updates on RCLK rise.
   always @(posedge fifo_rclk) begin
      if (!fifo_rrst) rd_ptr = 4'd0;
      else begin
         fifo_do = mem[rd_ptr];
         rd_ptr  = rd_ptr + 4'd1;
      end
   end

   always @(posedge fifo_rclk_b) begin
      if (!fifo_rrst_b) rd_ptr_b = 4'd0;
      else begin
         fifo_do_b = mem[rd_ptr_b];
         rd_ptr_b  = rd_ptr_b + 4'd1;
      end
   end

   function automatic logic [15:0] pack(input logic [7:0] even_b, input logic [7:0] odd_b);
`ifdef OV7670_RD_BYTE_SWAP_EN
      return {odd_b, even_b};
`else
      return {even_b, odd_b};
`endif
   endfunction

   // Expected 4x2 frame from the current FIFO contents.
   function automatic void push_frame();
      exp_t e;
      for (int p = 0; p < 8; p++) begin
         e.data = pack(mem[2*p], mem[2*p+1]);
         e.sof  = (p == 0);
         e.eol  = ((p % 4) == 3);
         e.eof  = (p == 7);
         sb.push_back(e);
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({fifo_rclk, fifo_rrst, fifo_oe, pix_valid, pix_sof, pix_eol, pix_eof, r_idle} !== 8'b0110_0001)
         begin n_fail++; $display("FAIL reset_ctrl: got %b want 01100001", {fifo_rclk, fifo_rrst, fifo_oe, pix_valid, pix_sof, pix_eol, pix_eof, r_idle}); end
      n_checks++;
      if (pix_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", pix_data); end
      n_checks++;
      if ({fifo_rclk_b, fifo_rrst_b, fifo_oe_b, pix_valid_b, r_idle_b} !== 5'b01101)
         begin n_fail++; $display("FAIL reset_ctrl_div3: got %b want 01101", {fifo_rclk_b, fifo_rrst_b, fifo_oe_b, pix_valid_b, r_idle_b}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_normal();
      exp_t got, exp;
      int   rises, k, last_c, late;
      logic prev;
      for (int i = 0; i < 16; i++) mem[i] = 8'(i);
      push_frame();
      wr_frame = 1'b1;
      @(negedge clk);
      wr_frame = 1'b0;
      n_checks++;
      if (r_idle !== 1'b0) begin n_fail++; $display("FAIL normal_r_idle_drop: got %b want 0", r_idle); end
      rises = 0; k = 0; last_c = 0; prev = fifo_rclk;
      for (int c = 0; c < 400 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (fifo_rclk && !prev && !fifo_rrst) rises++;
         prev = fifo_rclk;
         if (pix_valid && pix_ready) begin
            got = {pix_data, pix_sof, pix_eol, pix_eof};
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL normal_pixel%0d: got %h want %h", k, got, exp); end
            if (k > 0) begin
               n_checks++;
               if (c - last_c != 4) begin n_fail++; $display("FAIL normal_rate: got %0d cycles want 4", c - last_c); end
            end
            last_c = c;
            k++;
         end
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL normal_timeout: got %0d pixels left want 0", sb.size()); sb.delete(); end
      n_checks++;
      if (rises != 4) begin n_fail++; $display("FAIL normal_rrst_cycles: got %0d want 4", rises); end
      late = 0;
      repeat (10) begin @(negedge clk); if (fifo_rclk) late++; end
      n_checks++;
      if (late != 0) begin n_fail++; $display("FAIL normal_rclk_after_eof: got %0d high cycles want 0", late); end
      n_checks++;
      if (r_idle !== 1'b1 || fifo_oe !== 1'b1) begin n_fail++; $display("FAIL normal_r_idle_end: got idle=%b oe=%b want 1 1", r_idle, fifo_oe); end
   endtask

   task automatic test_backpressure();
      exp_t       got, exp;
      int         k, unstable;
      logic       stalled;
      logic [15:0] held;
      for (int i = 0; i < 16; i++) mem[i] = 8'(i);
      push_frame();
      wr_frame = 1'b1;
      @(negedge clk);
      wr_frame = 1'b0;
      k = 0; stalled = 1'b0;
      for (int c = 0; c < 600 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (k == 2 && pix_valid && !stalled) begin
            stalled   = 1'b1;
            pix_ready = 1'b0;
            held      = pix_data;
            n_checks++;
            if (held !== pack(8'h04, 8'h05)) begin n_fail++; $display("FAIL bp_pixel2: got %h want %h", held, pack(8'h04, 8'h05)); end
            unstable = 0;
            repeat (10) begin
               @(negedge clk);
               if (pix_data !== held || pix_valid !== 1'b1) unstable++;
            end
            n_checks++;
            if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changed cycles want 0", unstable); end
            n_checks++;
            if (fifo_rclk !== 1'b1) begin n_fail++; $display("FAIL bp_rclk_held: got %b want 1", fifo_rclk); end
            pix_ready = 1'b1;
         end
         if (pix_valid && pix_ready) begin
            got = {pix_data, pix_sof, pix_eol, pix_eof};
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL bp_pixel%0d: got %h want %h", k, got, exp); end
            k++;
         end
      end
      n_checks++;
      if (sb.size() != 0 || !stalled) begin n_fail++; $display("FAIL bp_timeout: got %0d left stalled=%b want 0 1", sb.size(), stalled); sb.delete(); end
      pix_ready = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_retrigger();
      exp_t got, exp;
      int   k, idle_low, extra;
      for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);
      push_frame();
      wr_frame = 1'b1;
      @(negedge clk);
      wr_frame = 1'b0;
      k = 0;
      for (int c = 0; c < 400 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (k == 3) wr_frame = 1'b1;
         if (pix_valid && pix_ready) begin
            got = {pix_data, pix_sof, pix_eol, pix_eof};
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL retrig_pixel%0d: got %h want %h", k, got, exp); end
            k++;
         end
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL retrig_timeout: got %0d left want 0", sb.size()); sb.delete(); end
      repeat (3) @(negedge clk);
      idle_low = 0; extra = 0;
      repeat (60) begin
         @(negedge clk);
         if (r_idle !== 1'b1) idle_low++;
         if (pix_valid) extra++;
      end
      n_checks++;
      if (idle_low != 0) begin n_fail++; $display("FAIL retrig_r_idle: got %0d low cycles want 0", idle_low); end
      n_checks++;
      if (extra != 0) begin n_fail++; $display("FAIL retrig_second_frame: got %0d valid cycles want 0", extra); end
      wr_frame = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      exp_t got, exp;
      int   k;
      logic hit;
      for (int i = 0; i < 16; i++) mem[i] = 8'h80 + 8'(i);
      push_frame();
      wr_frame = 1'b1;
      @(negedge clk);
      wr_frame = 1'b0;
      k = 0; hit = 1'b0;
      for (int c = 0; c < 400 && !hit; c++) begin
         @(negedge clk);
         if (k == 3 && pix_valid) begin
            rst = 1'b1;
            hit = 1'b1;
         end else if (pix_valid && pix_ready) begin
            got = {pix_data, pix_sof, pix_eol, pix_eof};
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL rstmid_pixel%0d: got %h want %h", k, got, exp); end
            k++;
         end
      end
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (!hit || {fifo_rclk, fifo_rrst, fifo_oe, pix_valid, pix_sof, pix_eol, pix_eof, r_idle} !== 8'b0110_0001 || pix_data !== 16'h0)
         begin n_fail++; $display("FAIL rstmid_outputs: got %b data %h want 01100001 data 0000", {fifo_rclk, fifo_rrst, fifo_oe, pix_valid, pix_sof, pix_eol, pix_eof, r_idle}, pix_data); end
      sb.delete();
      push_frame();
      @(negedge clk);
      wr_frame = 1'b1;
      @(negedge clk);
      wr_frame = 1'b0;
      k = 0;
      for (int c = 0; c < 400 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (pix_valid && pix_ready) begin
            got = {pix_data, pix_sof, pix_eol, pix_eof};
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL rstmid_restart%0d: got %h want %h", k, got, exp); end
            k++;
         end
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL rstmid_timeout: got %0d left want 0", sb.size()); sb.delete(); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_divider();
      exp_t got, exp;
      int   k, last_c, hi_run, lo_run, bad_hi, bad_lo, n_hi, n_lo;
      logic prev;
      for (int i = 0; i < 16; i++) mem[i] = 8'hC0 + 8'(i);
      push_frame();
      wr_frame_b = 1'b1;
      @(negedge clk);
      wr_frame_b = 1'b0;
      k = 0; last_c = 0; hi_run = 0; lo_run = 0; bad_hi = 0; bad_lo = 0; n_hi = 0; n_lo = 0;
      prev = fifo_rclk_b;
      for (int c = 0; c < 1000 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (prev && !fifo_rclk_b && fifo_rrst_b) begin n_hi++; if (hi_run != 3) bad_hi++; end
         if (!prev && fifo_rclk_b && fifo_rrst_b) begin n_lo++; if (lo_run != 3) bad_lo++; end
         if (fifo_rclk_b != prev) begin hi_run = 0; lo_run = 0; end
         if (fifo_rclk_b) hi_run++; else lo_run++;
         prev = fifo_rclk_b;
         if (pix_valid_b && pix_ready_b) begin
            got = {pix_data_b, pix_sof_b, pix_eol_b, pix_eof_b};
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL div3_pixel%0d: got %h want %h", k, got, exp); end
            if (k > 0) begin
               n_checks++;
               if (c - last_c != 12) begin n_fail++; $display("FAIL div3_rate: got %0d cycles want 12", c - last_c); end
            end
            last_c = c;
            k++;
         end
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL div3_timeout: got %0d left want 0", sb.size()); sb.delete(); end
      n_checks++;
      if (bad_hi != 0 || n_hi < 15) begin n_fail++; $display("FAIL div3_high_phase: got %0d bad of %0d want 0 of >=15", bad_hi, n_hi); end
      n_checks++;
      if (bad_lo != 0 || n_lo < 15) begin n_fail++; $display("FAIL div3_low_phase: got %0d bad of %0d want 0 of >=15", bad_lo, n_lo); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_swap();
      exp_t        got, exp;
      int          k;
      logic [15:0] first_lit;
`ifdef OV7670_RD_BYTE_SWAP_EN
      first_lit = 16'hCDAB;
`else
      first_lit = 16'hABCD;
`endif
      for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7);
      mem[0] = 8'hAB;
      mem[1] = 8'hCD;
      push_frame();
      wr_frame = 1'b1;
      @(negedge clk);
      wr_frame = 1'b0;
      k = 0;
      for (int c = 0; c < 400 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (pix_valid && pix_ready) begin
            got = {pix_data, pix_sof, pix_eol, pix_eof};
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL swap_pixel%0d: got %h want %h", k, got, exp); end
            if (k == 0) begin
               n_checks++;
               if (pix_data !== first_lit) begin n_fail++; $display("FAIL swap_first: got %h want %h", pix_data, first_lit); end
            end
            k++;
         end
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL swap_timeout: got %0d left want 0", sb.size()); sb.delete(); end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      rst         = 1'b1;
      wr_frame    = 1'b0;
      wr_frame_b  = 1'b0;
      pix_ready   = 1'b1;
      pix_ready_b = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      @(negedge clk);
      test_reset();
      test_normal();
      test_backpressure();
      test_retrigger();
      test_reset_mid();
      test_divider();
      test_swap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ov7670_fifo_read.md
Name: ov7670_fifo_read

Overview:
- Read-side controller for the AL422B frame FIFO behind the OV7670 camera.
- The capture controller writes one frame and then raises WR_FRAME. This block then resets the FIFO read pointer, clocks out 2*H_ACTIVE*V_ACTIVE bytes and packs them into RGB565 pixels.
- Pixels go out on a valid/ready stream for the display/SDRAM path.
- R_IDLE is returned to the capture controller so it can start the next frame.

Parameters:
- H_ACTIVE, 320, pixels per line.
- V_ACTIVE, 240, lines per frame.
- RCLK_DIV, 1, SYS_CLK cycles per FIFO_RCLK phase (high or low); must be at least 1.
- RRST_CYCLES, 4, FIFO_RCLK cycles with FIFO_RRST held low.

Ports:
- SYS_CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- WR_FRAME  in  1  frame-written flag from the capture controller, synchronous to SYS_CLK.
- FIFO_DO  in  8  AL422B read data.
- FIFO_RCLK  out  1  AL422B read clock.
- FIFO_RRST  out  1  AL422B read-pointer reset, active low.
- FIFO_OE  out  1  AL422B output enable, active low.
- PIX_DATA  out  16  RGB565 pixel.
- PIX_VALID  out  1  pixel valid.
- PIX_READY  in  1  downstream accept.
- PIX_SOF  out  1  qualifies the first pixel of the frame.
- PIX_EOL  out  1  qualifies the last pixel of each line.
- PIX_EOF  out  1  qualifies the last pixel of the frame.
- R_IDLE  out  1  high when no frame read is in progress.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (also apply when RST is asserted mid-frame, which aborts the frame with no partial flush):
  - FIFO_RCLK=0, FIFO_RRST=1, FIFO_OE=1.
  - PIX_DATA=0, PIX_VALID=0, PIX_SOF=0, PIX_EOL=0, PIX_EOF=0.
  - R_IDLE=1, state IDLE.
  - wr_frame_d=0, so a WR_FRAME that is still high after reset does not start a read.
- Start condition: a rising edge of WR_FRAME (WR_FRAME=1 and registered wr_frame_d=0) while in IDLE.
  - R_IDLE drops on that same edge, so it is low one cycle later. The capture controller samples R_IDLE two cycles after raising WR_FRAME and must see it low.
  - Rising edges outside IDLE are ignored; they are not queued.
  - A WR_FRAME level held high never retriggers.
- States:
  - IDLE -> RRST on start.
  - RRST -> READ: FIFO_RRST=0, FIFO_OE=1, FIFO_RCLK toggling for RRST_CYCLES full cycles. Then FIFO_RRST=1 and FIFO_OE=0 on the same edge.
  - READ -> DONE once the EOF pixel is accepted.
  - DONE -> IDLE: FIFO_OE=1, R_IDLE=1 on entry to IDLE.
- RCLK timing:
  - Each byte is one RCLK cycle: RCLK_DIV cycles high, then RCLK_DIV cycles low.
  - FIFO_DO is registered on the SYS_CLK edge that drives FIFO_RCLK from high to low.
- Byte order and packing:
  - Even byte is the high byte PIX_DATA[15:8]; odd byte is the low byte [7:0].
  - The pixel loads into the output register when the odd byte is captured.
- Stall rule: at the end of an odd-byte high phase, if PIX_VALID=1 and PIX_READY=0, FIFO_RCLK stays high and capture is deferred until PIX_READY=1.
  - PIX_VALID=1 with PIX_READY=1 on the same cycle frees the register; no stall.
  - PIX_DATA and the flags are stable while PIX_VALID=1 and PIX_READY=0.
- Counters:
  - col counts 0..H_ACTIVE-1 with width $clog2(H_ACTIVE); row counts 0..V_ACTIVE-1 with width $clog2(V_ACTIVE).
  - Both advance on pixel load; col wraps to 0 and row increments at line end. Both clear on start.
- Flags:
  - PIX_SOF when row=0 and col=0.
  - PIX_EOL when col=H_ACTIVE-1.
  - PIX_EOF when col=H_ACTIVE-1 and row=V_ACTIVE-1.
- Throughput: with no stalls, one pixel per 4*RCLK_DIV SYS_CLK cycles.
- No RCLK edge occurs after the EOF byte capture.

Optional Feature:
- Macro: OV7670_RD_BYTE_SWAP_EN.
- Defined: the even byte goes to PIX_DATA[7:0] and the odd byte to [15:8]. This matches a sensor programmed for low-byte-first output.
- Undefined: high byte first, as described above.
- Counters, flags and timing are identical either way.

Decomposition:
- Package ov7670_pkg:
  - read state enum (IDLE, RRST, READ, DONE);
  - default frame constants 320/240;
  - RGB565 pixel typedef.
- Sub-module ov7670_rclk_gen:
  - RCLK_DIV phase counter;
  - outputs FIFO_RCLK plus single-cycle rise and fall strobes;
  - a hold input implements the stall;
  - an enable input gates toggling.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, RCLK_DIV=1 unless stated):
1. Normal frame. Stimulus: PIX_READY=1, pulse WR_FRAME, FIFO model returns bytes 0x00..0x0F. Response:
   - R_IDLE low one cycle after the edge;
   - exactly 4 RRST RCLK cycles with FIFO_RRST=0;
   - 8 pixels 0x0001, 0x0203, ... 0x0E0F;
   - SOF on pixel 0, EOL on pixels 3 and 7, EOF on pixel 7;
   - R_IDLE high after EOF.
2. Backpressure. Stimulus: PIX_READY low for 10 cycles at pixel 2. Response: FIFO_RCLK held high; PIX_DATA=0x0405 stable; no byte lost; sequence continues 0x0607.
3. Retrigger and level. Stimulus: a second WR_FRAME rise mid-frame, then WR_FRAME held high after DONE. Response: exactly one frame read; R_IDLE stays 1.
4. Reset mid-frame. Stimulus: assert RST at pixel 3. Response: all outputs at reset values next cycle; a new WR_FRAME edge restarts from SOF with row/col at 0.
5. Divider. Stimulus: RCLK_DIV=3. Response: RCLK high 3 / low 3 cycles; one pixel every 12 cycles.
6. Swap. Stimulus: OV7670_RD_BYTE_SWAP_EN defined with bytes 0xAB, 0xCD. Response: PIX_DATA=0xCDAB.
